// File: rtl/prim_arbiter_wrr.sv
// rtl/prim_arbiter_wrr.sv - N:1 weighted round-robin arbiter with packet locking
module prim_arbiter_wrr #(
    parameter int unsigned N          = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned WW         = 4,
    parameter bit          EnDataPort = 1'b1,
    localparam int unsigned IdxW      = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0]        last_i,
    input  logic [DW-1:0]       data_i   [N],
    input  logic [WW-1:0]       weight_i [N],
    output logic [N-1:0]        gnt_o,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o,
    output logic [DW-1:0]       data_o,
    output logic                last_o,
    input  logic                ready_i
);

    logic [IdxW-1:0] ptr_q;
    logic [WW-1:0]   credit_q;
    logic            lock_q;

    logic            keep;
    logic [IdxW-1:0] rr_idx;
    logic [IdxW-1:0] winner;
    logic [WW-1:0]   cur_credit;
    logic            grant;

    // Scan from the far end toward ptr_q+1 so the nearest requester after ptr_q wins.
    always_comb begin
        rr_idx = '0;
        for (int off = N; off >= 1; off--) begin
            if (req_i[IdxW'((int'(ptr_q) + off) % int'(N))]) begin
                rr_idx = IdxW'((int'(ptr_q) + off) % int'(N));
            end
        end
    end

    always_comb begin
        keep       = lock_q | (req_i[ptr_q] & (credit_q != '0));
        winner     = keep ? ptr_q : rr_idx;
        valid_o    = req_i[winner];
        idx_o      = winner;
        last_o     = last_i[winner];
        data_o     = EnDataPort ? data_i[winner] : '1;
        grant      = valid_o & ready_i;
        gnt_o      = grant ? (N'(1) << winner) : '0;
        cur_credit = credit_q;
        if (!keep) begin
            cur_credit = (weight_i[winner] == '0) ? WW'(1) : weight_i[winner];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= IdxW'(N - 1);
            credit_q <= '0;
            lock_q   <= 1'b0;
        end else if (grant) begin
            ptr_q <= winner;
            if (last_o) begin
                credit_q <= cur_credit - WW'(1);
                lock_q   <= 1'b0;
            end else begin
                credit_q <= cur_credit;
                lock_q   <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_gnt_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o != '0) |-> ready_i);
    a_gnt_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ready_i & valid_o) |-> gnt_o[idx_o]);
    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> (idx_o == $past(idx_o)));
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ($past(valid_o & ~ready_i) && $stable(req_i)) |-> $stable(idx_o));
    a_data: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (EnDataPort && valid_o) |-> (data_o == data_i[idx_o]));
    a_no_x: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({gnt_o, idx_o, valid_o, last_o, data_o}));
`endif

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// tb/tb_prim_arbiter_wrr.sv - directed-vector bench for prim_arbiter_wrr
module tb_prim_arbiter_wrr;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  req_i;
    logic [N-1:0]  last_i;
    logic [DW-1:0] data_i   [N];
    logic [WW-1:0] weight_i [N];
    logic [N-1:0]  gnt_o;
    logic [1:0]    idx_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    prim_arbiter_wrr #(.N(N), .DW(DW), .WW(WW), .EnDataPort(1'b1)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .last_i   (last_i),
        .data_i   (data_i),
        .weight_i (weight_i),
        .gnt_o    (gnt_o),
        .idx_o    (idx_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .ready_i  (ready_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic set_weights(input int w3, input int w2, input int w1, input int w0);
        weight_i[3] = WW'(w3);
        weight_i[2] = WW'(w2);
        weight_i[1] = WW'(w1);
        weight_i[0] = WW'(w0);
    endtask

    int seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int seq2 [8] = '{0, 1, 2, 3, 3, 3, 0, 1};

    initial begin
        for (int k = 0; k < N; k++) data_i[k] = DW'(8'hA0 + k);
        set_weights(1, 1, 1, 1);
        req_i   = '0;
        last_i  = '1;
        ready_i = 1'b1;
        rst_ni  = 1'b0;
        tick();
        sample();
        check("rst_valid", 32'(valid_o), 0);
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_idx", 32'(idx_o), 0);
        check("rst_ptr", 32'(dut.ptr_q), 3);
        check("rst_credit", 32'(dut.credit_q), 0);
        tick();
        rst_ni = 1'b1;

        // 1: plain round robin
        req_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("t1_idx", 32'(idx_o), 32'(seq1[i]));
            check("t1_gnt", 32'(gnt_o), 32'(1 << seq1[i]));
            check("t1_data", 32'(data_o), 32'(8'hA0 + seq1[i]));
            tick();
        end

        // 2: port3 gets three packets per turn
        req_i = '0;
        do_reset();
        set_weights(3, 1, 1, 1);
        req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("t2_idx", 32'(idx_o), 32'(seq2[i]));
            check("t2_gnt", 32'(gnt_o), 32'(1 << seq2[i]));
            tick();
        end

        // 3: three-beat packet on port0 holds the grant
        req_i = '0;
        set_weights(1, 1, 1, 1);
        do_reset();
        req_i  = 4'b0011;
        last_i = 4'b1110;
        sample();
        check("t3_b1_gnt", 32'(gnt_o), 32'b0001);
        check("t3_b1_last", 32'(last_o), 0);
        tick();
        sample();
        check("t3_b2_gnt", 32'(gnt_o), 32'b0001);
        check("t3_b2_lock", 32'(dut.lock_q), 1);
        tick();
        last_i = 4'b1111;
        sample();
        check("t3_b3_gnt", 32'(gnt_o), 32'b0001);
        check("t3_b3_lock", 32'(dut.lock_q), 1);
        check("t3_b3_last", 32'(last_o), 1);
        tick();
        sample();
        check("t3_next_gnt", 32'(gnt_o), 32'b0010);
        check("t3_unlock", 32'(dut.lock_q), 0);
        tick();

        // 4: back-pressure holds selection and state
        req_i = '0;
        do_reset();
        req_i   = 4'b0101;
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t4_stall_idx", 32'(idx_o), 0);
            check("t4_stall_gnt", 32'(gnt_o), 0);
            check("t4_stall_valid", 32'(valid_o), 1);
            check("t4_stall_ptr", 32'(dut.ptr_q), 3);
            tick();
        end
        ready_i = 1'b1;
        sample();
        check("t4_gnt0", 32'(gnt_o), 32'b0001);
        tick();
        sample();
        check("t4_gnt2", 32'(gnt_o), 32'b0100);
        tick();

        // 5: zero weight behaves as one, sole requester re-wins
        req_i = '0;
        do_reset();
        set_weights(1, 1, 0, 1);
        req_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t5_gnt", 32'(gnt_o), 32'b0010);
            tick();
            check("t5_credit", 32'(dut.credit_q), 0);
        end

        // 6: reset in the middle of a packet
        set_weights(1, 1, 1, 1);
        req_i = '0;
        do_reset();
        req_i  = 4'b0100;
        last_i = 4'b1011;
        sample();
        check("t6_pre_gnt", 32'(gnt_o), 32'b0100);
        tick();
        check("t6_pre_lock", 32'(dut.lock_q), 1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_lock", 32'(dut.lock_q), 0);
        check("t6_rst_credit", 32'(dut.credit_q), 0);
        tick();
        rst_ni = 1'b1;
        req_i  = 4'b1100;
        last_i = 4'b1111;
        sample();
        check("t6_first_gnt", 32'(gnt_o), 32'b0100);
        tick();
        check("t6_lock_after", 32'(dut.lock_q), 0);
        sample();
        check("t6_second_gnt", 32'(gnt_o), 32'b1000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
